// File: rtl/lcd_cursor.sv
// lcd_cursor: HD44780-style 8-bit text LCD controller with a movable cursor on
// line 1 (16 columns). Runs the power-up init sequence, then idles waiting for
// button presses: a digit key writes its ASCII digit at the cursor and advances
// it; left/right keys move the cursor. Every cursor change re-issues the DDRAM
// address so the visible cursor follows.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   number_btn   in   [9:0] digit keys, bit n = digit n (rising edge = press)
//   control_btn  in   [1] cursor left, [0] cursor right (rising edge = press)
//   LCD_E        out  LCD enable strobe
//   LCD_RS       out  0 = command, 1 = data
//   LCD_RW       out  tied 0 (write only)
//   LCD_DATA     out  [7:0] LCD bus byte
//   LED_out      out  [7:4] cursor column, [3:0] last digit written
//
// Build option
//   LCD_CURSOR_BLINK_EN  defined: display-on command enables cursor blink (0x0F)
//                        undefined: cursor shown without blink (0x0E)
module lcd_cursor #(
  parameter int unsigned DELAY_CNT = 70,
  parameter int unsigned CMD_CNT   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] number_btn,
  input  logic [1:0] control_btn,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic [7:0] LED_out
);

  localparam int unsigned CNT_MAX = (DELAY_CNT > CMD_CNT) ? DELAY_CNT : CMD_CNT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [7:0] DISP_CMD = 8'h0F;
`else
  localparam logic [7:0] DISP_CMD = 8'h0E;
`endif

  typedef enum logic [2:0] {
    DELAY, FUNCTION_SET, DISP_ONOFF, ENTRY_MODE,
    CLEAR_DISP, DELAY_T, WRITE_CHAR, SET_ADDR
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    last_q, last_d;
  logic [11:0]   btn_prev_q;
  logic          e_q, e_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;

  logic [11:0]   btn_now;
  logic [11:0]   btn_edge;
  logic          last_cyc;
  logic [3:0]    pos_inc;
  logic          digit_found;
  logic [3:0]    digit;

  assign btn_now  = {control_btn, number_btn};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign pos_inc  = (pos_q == 4'hF) ? pos_q : pos_q + 4'd1;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    last_d      = last_q;
    rs_d        = rs_q;
    data_d      = data_q;
    e_d         = 1'b0;
    digit_found = 1'b0;
    digit       = '0;

    last_cyc = (state == DELAY) ? (cnt_q == CW'(DELAY_CNT - 1))
                                : (cnt_q == CW'(CMD_CNT - 1));

    if (state != DELAY_T) begin
      cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    // Lowest-index digit wins among simultaneous digit edges.
    for (int unsigned i = 0; i < 10; i++) begin
      if (btn_edge[i] && !digit_found) begin
        digit_found = 1'b1;
        digit       = 4'(i);
      end
    end

    case (state)
      DELAY:        if (last_cyc) state_d = FUNCTION_SET;
      FUNCTION_SET: if (last_cyc) state_d = DISP_ONOFF;
      DISP_ONOFF:   if (last_cyc) state_d = ENTRY_MODE;
      ENTRY_MODE:   if (last_cyc) state_d = CLEAR_DISP;
      CLEAR_DISP:   if (last_cyc) state_d = DELAY_T;
      DELAY_T: begin
        if (btn_edge[11]) begin
          pos_d   = (pos_q == 4'h0) ? pos_q : pos_q - 4'd1;
          state_d = SET_ADDR;
        end else if (btn_edge[10]) begin
          pos_d   = pos_inc;
          state_d = SET_ADDR;
        end else if (digit_found) begin
          last_d  = digit;
          state_d = WRITE_CHAR;
        end
      end
      WRITE_CHAR: begin
        if (last_cyc) begin
          pos_d   = pos_inc;
          state_d = SET_ADDR;
        end
      end
      SET_ADDR:     if (last_cyc) state_d = DELAY_T;
      default:      state_d = DELAY;
    endcase

    // Bus outputs are registered from next-state values so they line up
    // exactly with the state/cnt they belong to; idle holds the last byte.
    case (state_d)
      DELAY:        begin rs_d = 1'b0; data_d = 8'h00; end
      FUNCTION_SET: begin rs_d = 1'b0; data_d = 8'h38; end
      DISP_ONOFF:   begin rs_d = 1'b0; data_d = DISP_CMD; end
      ENTRY_MODE:   begin rs_d = 1'b0; data_d = 8'h06; end
      CLEAR_DISP:   begin rs_d = 1'b0; data_d = 8'h01; end
      WRITE_CHAR:   begin rs_d = 1'b1; data_d = 8'h30 | {4'h0, last_d}; end
      SET_ADDR:     begin rs_d = 1'b0; data_d = {4'h8, pos_d}; end
      default:      ;
    endcase

    e_d = (state_d != DELAY) && (state_d != DELAY_T) &&
          (cnt_d >= CW'(2)) && (cnt_d <= CW'(CMD_CNT - 3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DELAY;
      cnt_q      <= '0;
      pos_q      <= '0;
      last_q     <= '0;
      btn_prev_q <= '0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state      <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      last_q     <= last_d;
      btn_prev_q <= btn_now;
      e_q        <= e_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
    end
  end

  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;
  assign LED_out  = {pos_q, last_q};

endmodule

// File: tb/tb_lcd_cursor.sv
// Self-checking bench for lcd_cursor. Every E-high window is captured as one
// {RS,DATA} transaction; expected transactions come from a cursor model that
// applies the key rules directly to an integer column and last digit.
module tb_lcd_cursor;
  localparam int DELAY_CNT = 70;
  localparam int CMD_CNT   = 30;
  localparam int SETTLE    = 2 * CMD_CNT + 10;

`ifdef LCD_CURSOR_BLINK_EN
  localparam logic [8:0] DISP_EXP = 9'h00F;
`else
  localparam logic [8:0] DISP_EXP = 9'h00E;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] number_btn = '0;
  logic [1:0] control_btn = '0;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA, LED_out;

  always #5 clk = ~clk;

  lcd_cursor #(.DELAY_CNT(DELAY_CNT), .CMD_CNT(CMD_CNT)) dut (
    .clk(clk), .rst(rst), .number_btn(number_btn), .control_btn(control_btn),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA),
    .LED_out(LED_out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int m_pos  = 0;
  int m_last = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transaction monitor, sampling on the falling edge.
  bit         mon_active = 0;
  int         mon_len = 0;
  logic [8:0] mon_cur;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 0;
    end else if (LCD_E && !mon_active) begin
      mon_active = 1;
      mon_len    = 1;
      mon_cur    = {LCD_RS, LCD_DATA};
      got_q.push_back(mon_cur);
      chk("rw_low", 32'(LCD_RW), 32'd0);
    end else if (LCD_E) begin
      mon_len++;
      chk("bus_stable", 32'({LCD_RS, LCD_DATA}), 32'(mon_cur));
    end else if (mon_active) begin
      mon_active = 0;
      chk("e_width", 32'(mon_len), 32'(CMD_CNT - 4));
    end
  end

  function automatic void model_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(DISP_EXP);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
  endfunction

  function automatic void model_press(logic [1:0] c, logic [9:0] n);
    int d = -1;
    for (int i = 9; i >= 0; i--) if (n[i]) d = i;
    if (c[1]) begin
      m_pos = (m_pos > 0) ? m_pos - 1 : 0;
      exp_q.push_back(9'(128 + m_pos));
    end else if (c[0]) begin
      m_pos = (m_pos < 15) ? m_pos + 1 : 15;
      exp_q.push_back(9'(128 + m_pos));
    end else if (d >= 0) begin
      exp_q.push_back(9'(256 + 48 + d));
      m_last = d;
      m_pos  = (m_pos < 15) ? m_pos + 1 : 15;
      exp_q.push_back(9'(128 + m_pos));
    end
  endfunction

  task automatic check_run(string tag);
    int n;
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_xfer%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s_led", tag), 32'(LED_out), 32'(m_pos * 16 + m_last));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse(logic [1:0] c, logic [9:0] n);
    @(posedge clk); #1;
    control_btn = c;
    number_btn  = n;
    @(posedge clk); #1;
    control_btn = '0;
    number_btn  = '0;
  endtask

  task automatic press(string tag, logic [1:0] c, logic [9:0] n);
    pulse(c, n);
    model_press(c, n);
    repeat (SETTLE) @(posedge clk);
    check_run(tag);
  endtask

  initial begin
    logic [1:0] rc;
    logic [9:0] rn;
    int r;

    // Reset for two edges and check reset outputs.
    @(posedge clk); #1;
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'd0);
    chk("rst_led", 32'(LED_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle is entered exactly DELAY_CNT+4*CMD_CNT edges after release:
    // a press sampled one edge earlier is dropped, one sampled at the first
    // idle edge is taken.
    repeat (DELAY_CNT + 4 * CMD_CNT - 1) @(posedge clk);
    #1 number_btn = 10'(1 << 3);
    @(posedge clk); #1 number_btn = 10'(1 << 9);
    @(posedge clk); #1 number_btn = '0;
    model_init();
    model_press(2'b00, 10'(1 << 9));
    repeat (SETTLE) @(posedge clk);
    check_run("init_d9");
    chk("led_d9", 32'(LED_out), 32'h19);

    press("d4", 2'b00, 10'(1 << 4));
    chk("led_d4", 32'(LED_out), 32'h24);
    press("left", 2'b10, '0);
    chk("led_left", 32'(LED_out), 32'h14);
    press("right", 2'b01, '0);
    chk("led_right", 32'(LED_out), 32'h24);
    for (int i = 0; i < 3; i++) press($sformatf("lsat%0d", i), 2'b10, '0);
    chk("led_lsat", 32'(LED_out), 32'h04);
    for (int i = 0; i < 16; i++) press($sformatf("rsat%0d", i), 2'b01, '0);
    chk("led_rsat", 32'(LED_out), 32'hF4);

    // Presses during a write are discarded.
    press("left_back", 2'b10, '0);
    pulse(2'b00, 10'(1 << 2));
    model_press(2'b00, 10'(1 << 2));
    repeat (5) @(posedge clk);
    pulse(2'b11, 10'h3FF);
    repeat (SETTLE) @(posedge clk);
    check_run("busy_ignore");

    press("both_ctl", 2'b11, 10'h001);

    // Randomized key mix, including simultaneous presses.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      rc = (r < 2) ? 2'b10 : (r < 4) ? 2'b01 : (r == 4) ? 2'b11 : 2'b00;
      rn = ($urandom_range(0, 1) == 0) ? 10'(1 << $urandom_range(0, 9))
                                       : 10'($urandom_range(0, 1023));
      press($sformatf("rnd%0d", k), rc, rn);
    end

    // Reset in the middle of SET_ADDR.
    pulse(2'b00, 10'(1 << 5));
    for (int k = 0; k < 4 * CMD_CNT && got_q.size() < 2; k++) @(posedge clk);
    chk("rst_reach", 32'(got_q.size()), 32'd2);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_e", 32'(LCD_E), 32'd0);
    chk("mid_rst_rs", 32'(LCD_RS), 32'd0);
    chk("mid_rst_data", 32'(LCD_DATA), 32'd0);
    chk("mid_rst_led", 32'(LED_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    m_pos  = 0;
    m_last = 0;
    repeat (DELAY_CNT + 4 * CMD_CNT + 10) @(posedge clk);
    model_init();
    check_run("reinit");
    press("post_rst", 2'b01, '0);
    chk("led_post_rst", 32'(LED_out), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
